// File: rtl/gpio_sram_scan_ctrl_pkg.sv
// rtl/gpio_sram_scan_ctrl_pkg.sv - shared frame layout and sizing for the SRAM scan controller
package gpio_sram_scan_ctrl_pkg;

    localparam int FRAME_W  = 112;
    localparam int NUM_SRAM = 16;
    localparam int NUM_DP   = 8;
    localparam int SEL_W    = 4;
    localparam int ADDR_W   = 16;
    localparam int DATA_W   = 32;
    localparam int MASK_W   = 4;

    // Field order is MSB first, so sel is the first group shifted in.
    typedef struct packed {
        logic [SEL_W-1:0]  sel;
        logic [ADDR_W-1:0] addr0;
        logic [DATA_W-1:0] din0;
        logic              csb0;
        logic              web0;
        logic [MASK_W-1:0] wmask0;
        logic [ADDR_W-1:0] addr1;
        logic [DATA_W-1:0] din1;
        logic              csb1;
        logic              web1;
        logic [MASK_W-1:0] wmask1;
    } frame_t;

endpackage

// File: rtl/scan_frame_reg.sv
// rtl/scan_frame_reg.sv - 112-bit command frame with serial shift and read-data load
module scan_frame_reg
    import gpio_sram_scan_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              scan,
    input  logic              serial_in,
    input  logic              load,
    input  logic [DATA_W-1:0] load_din0,
    input  logic [DATA_W-1:0] load_din1,
    output frame_t            frame
);

    // Shift has priority so a stray load pulse cannot corrupt a frame mid-scan.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            frame <= '0;
        end else if (scan) begin
            frame <= frame_t'({frame[FRAME_W-2:0], serial_in});
        end else if (load) begin
            frame.din0 <= load_din0;
            frame.din1 <= load_din1;
        end
    end

endmodule

// File: rtl/gpio_sram_scan_ctrl.sv
// rtl/gpio_sram_scan_ctrl.sv - GPIO scan-chain front end driving the test SRAM array
module gpio_sram_scan_ctrl
    import gpio_sram_scan_ctrl_pkg::*;
(
    input  logic                         gpio_clk,
    input  logic                         gpio_resetn,
    input  logic                         gpio_in,
    input  logic                         gpio_scan,
    input  logic                         gpio_sram_load,
    input  logic                         global_csb,
    output logic                         gpio_out,
    output logic [NUM_SRAM-1:0]          sram_csb0,
    output logic [NUM_SRAM-1:0]          sram_csb1,
    output logic                         sram_web0,
    output logic                         sram_web1,
    output logic [MASK_W-1:0]            sram_wmask0,
    output logic [MASK_W-1:0]            sram_wmask1,
    output logic [ADDR_W-1:0]            sram_addr0,
    output logic [ADDR_W-1:0]            sram_addr1,
    output logic [DATA_W-1:0]            sram_din0,
    output logic [DATA_W-1:0]            sram_din1,
    input  logic [NUM_SRAM*DATA_W-1:0]   sram_dout0,
    input  logic [NUM_SRAM*DATA_W-1:0]   sram_dout1
);

    frame_t            frame;
    logic [DATA_W-1:0] dout0_q;
    logic [DATA_W-1:0] dout1_q;
    logic              acc_q;
    logic              acc_dual_q;
    logic [SEL_W-1:0]  acc_sel_q;
    logic [8:0]        rd_base;

    scan_frame_reg u_frame (
        .clk       (gpio_clk),
        .rst_n     (gpio_resetn),
        .scan      (gpio_scan),
        .serial_in (gpio_in),
        .load      (gpio_sram_load),
        .load_din0 (dout0_q),
        .load_din1 (dout1_q),
        .frame     (frame)
    );

    assign gpio_out = frame[FRAME_W-1];

    // Reset gates every select so a cleared frame (sel=0, csb=0) cannot hit slot 0.
    always_comb begin
        sram_csb0 = '1;
        sram_csb1 = '1;
        for (int k = 0; k < NUM_SRAM; k++) begin
            sram_csb0[k] = !gpio_resetn || global_csb || frame.csb0 || (frame.sel != SEL_W'(k));
            sram_csb1[k] = (k >= NUM_DP) || !gpio_resetn || global_csb || frame.csb1
                           || (frame.sel != SEL_W'(k));
        end
    end

    assign sram_web0   = frame.web0;
    assign sram_web1   = frame.web1;
    assign sram_wmask0 = frame.wmask0;
    assign sram_wmask1 = frame.wmask1;
    assign sram_addr0  = frame.addr0;
    assign sram_addr1  = frame.addr1;
    assign sram_din0   = frame.din0;
    assign sram_din1   = frame.din1;

    assign rd_base = {acc_sel_q, 5'd0};

    // Slot and port-1 enable are latched with the access so capture uses the accessed slot.
    always_ff @(posedge gpio_clk or negedge gpio_resetn) begin
        if (!gpio_resetn) begin
            acc_q      <= 1'b0;
            acc_dual_q <= 1'b0;
            acc_sel_q  <= '0;
            dout0_q    <= '0;
            dout1_q    <= '0;
        end else begin
            acc_q      <= !global_csb;
            acc_sel_q  <= frame.sel;
            acc_dual_q <= !frame.csb1 && (frame.sel < SEL_W'(NUM_DP));
            if (acc_q) begin
                dout0_q <= sram_dout0[rd_base +: DATA_W];
                dout1_q <= acc_dual_q ? sram_dout1[rd_base +: DATA_W] : '0;
            end
        end
    end

endmodule

// File: tb/tb_gpio_sram_scan_ctrl.sv
// tb/tb_gpio_sram_scan_ctrl.sv - self-checking bench with behavioural SRAM array
module tb_gpio_sram_scan_ctrl;

    logic          gpio_clk;
    logic          gpio_resetn;
    logic          gpio_in;
    logic          gpio_scan;
    logic          gpio_sram_load;
    logic          global_csb;
    logic          gpio_out;
    logic [15:0]   sram_csb0;
    logic [15:0]   sram_csb1;
    logic          sram_web0;
    logic          sram_web1;
    logic [3:0]    sram_wmask0;
    logic [3:0]    sram_wmask1;
    logic [15:0]   sram_addr0;
    logic [15:0]   sram_addr1;
    logic [31:0]   sram_din0;
    logic [31:0]   sram_din1;
    logic [511:0]  sram_dout0;
    logic [511:0]  sram_dout1;

    gpio_sram_scan_ctrl dut (
        .gpio_clk       (gpio_clk),
        .gpio_resetn    (gpio_resetn),
        .gpio_in        (gpio_in),
        .gpio_scan      (gpio_scan),
        .gpio_sram_load (gpio_sram_load),
        .global_csb     (global_csb),
        .gpio_out       (gpio_out),
        .sram_csb0      (sram_csb0),
        .sram_csb1      (sram_csb1),
        .sram_web0      (sram_web0),
        .sram_web1      (sram_web1),
        .sram_wmask0    (sram_wmask0),
        .sram_wmask1    (sram_wmask1),
        .sram_addr0     (sram_addr0),
        .sram_addr1     (sram_addr1),
        .sram_din0      (sram_din0),
        .sram_din1      (sram_din1),
        .sram_dout0     (sram_dout0),
        .sram_dout1     (sram_dout1)
    );

    initial gpio_clk = 1'b0;
    always #5 gpio_clk = ~gpio_clk;

    // Shared-array dual-port SRAM per slot, registered read on the access edge.
    logic [31:0] mem [16][256];
    always @(posedge gpio_clk) begin
        for (int k = 0; k < 16; k++) begin
            if (!sram_csb0[k]) begin
                if (!sram_web0) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wmask0[b]) mem[k][sram_addr0[7:0]][8*b +: 8] <= sram_din0[8*b +: 8];
                end else begin
                    sram_dout0[32*k +: 32] <= mem[k][sram_addr0[7:0]];
                end
            end
            if (!sram_csb1[k]) begin
                if (!sram_web1) begin
                    for (int b = 0; b < 4; b++)
                        if (sram_wmask1[b]) mem[k][sram_addr1[7:0]][8*b +: 8] <= sram_din1[8*b +: 8];
                end else begin
                    sram_dout1[32*k +: 32] <= mem[k][sram_addr1[7:0]];
                end
            end
        end
    end

    typedef struct {
        logic [3:0]  sel;
        logic        dual;
        logic [15:0] a0;
        logic [31:0] d0;
        logic [15:0] a1;
        logic [31:0] d1;
        logic [31:0] exp0;
        logic [31:0] exp1;
    } vec_t;

    vec_t         vecs[$];
    logic [111:0] sb_q[$];
    int           n_cmp;
    int           n_err;

    function automatic logic [111:0] mk(input logic [3:0] sel, input logic [15:0] a0,
                                        input logic [31:0] d0, input logic c0, input logic w0,
                                        input logic [3:0] m0, input logic [15:0] a1,
                                        input logic [31:0] d1, input logic c1, input logic w1,
                                        input logic [3:0] m1);
        return {sel, a0, d0, c0, w0, m0, a1, d1, c1, w1, m1};
    endfunction

    task automatic check(input string name, input logic [111:0] act, input logic [111:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Samples gpio_out before each shift edge; optionally pops and compares a scoreboard entry.
    task automatic shift_frame(input logic [111:0] f, input bit compare, input string name);
        logic [111:0] got;
        bit           xseen;
        logic [111:0] exp;
        xseen = 1'b0;
        for (int i = 111; i >= 0; i--) begin
            @(negedge gpio_clk);
            got[i] = gpio_out;
            if ($isunknown(gpio_out)) xseen = 1'b1;
            gpio_in   = f[i];
            gpio_scan = 1'b1;
        end
        @(negedge gpio_clk);
        gpio_scan = 1'b0;
        gpio_in   = 1'b0;
        if (compare) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL %s: scoreboard empty, got %h", name, got);
            end else begin
                exp = sb_q.pop_front();
                check(name, got, exp);
                check({name, "_x"}, {111'd0, xseen}, 112'd0);
            end
        end
    endtask

    task automatic access(input logic [111:0] f);
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic [15:0] one;
        logic [3:0]  sel;
        one  = 16'h1;
        sel  = f[111:108];
        exp0 = f[59] ? 16'hFFFF : ~(one << sel);
        exp1 = (f[5] || sel >= 4'd8) ? 16'hFFFF : ~(one << sel);
        @(negedge gpio_clk);
        global_csb = 1'b0;
        #1;
        check($sformatf("csb0_sel%0d", sel), {96'd0, sram_csb0}, {96'd0, exp0});
        check($sformatf("csb1_sel%0d", sel), {96'd0, sram_csb1}, {96'd0, exp1});
        @(negedge gpio_clk);
        global_csb = 1'b1;
        #1;
        check("csb_idle", {80'd0, sram_csb1, sram_csb0}, {80'd0, 32'hFFFF_FFFF});
    endtask

    task automatic wr(input logic [111:0] f);
        shift_frame(f, 1'b0, "");
        access(f);
    endtask

    task automatic rd(input logic [111:0] f, input logic [111:0] exp, input string name);
        shift_frame(f, 1'b0, "");
        access(f);
        @(negedge gpio_clk);
        gpio_sram_load = 1'b1;
        @(negedge gpio_clk);
        gpio_sram_load = 1'b0;
        sb_q.push_back(exp);
        shift_frame(112'd0, 1'b1, name);
    endtask

    initial begin
        logic [111:0] pat_a;
        logic [111:0] pat_b;
        n_cmp          = 0;
        n_err          = 0;
        gpio_resetn    = 1'b0;
        gpio_in        = 1'b0;
        gpio_scan      = 1'b0;
        gpio_sram_load = 1'b0;
        global_csb     = 1'b0;

        vecs.push_back('{4'd3,  1'b1, 16'd1,  32'd3,         16'd2,   32'h18,        32'd3,         32'h18});
        vecs.push_back('{4'd0,  1'b1, 16'd4,  32'h0102_0304, 16'd5,   32'hA5A5_A5A5, 32'h0102_0304, 32'hA5A5_A5A5});
        vecs.push_back('{4'd1,  1'b1, 16'd10, 32'hFFFF_FFFF, 16'd11,  32'h0,         32'hFFFF_FFFF, 32'h0});
        vecs.push_back('{4'd2,  1'b1, 16'd0,  32'h8000_0001, 16'd255, 32'h7FFF_FFFE, 32'h8000_0001, 32'h7FFF_FFFE});
        vecs.push_back('{4'd4,  1'b1, 16'd3,  32'h1234_5678, 16'd4,   32'h9ABC_DEF0, 32'h1234_5678, 32'h9ABC_DEF0});
        vecs.push_back('{4'd5,  1'b1, 16'd1,  32'h55AA_55AA, 16'd2,   32'hAA55_AA55, 32'h55AA_55AA, 32'hAA55_AA55});
        vecs.push_back('{4'd6,  1'b1, 16'd20, 32'h0000_0001, 16'd21,  32'h8000_0000, 32'h0000_0001, 32'h8000_0000});
        vecs.push_back('{4'd9,  1'b0, 16'd1,  32'hDEAD_BEEF, 16'd2,   32'h0,         32'hDEAD_BEEF, 32'h0});
        vecs.push_back('{4'd8,  1'b0, 16'd6,  32'hCAFE_0008, 16'd2,   32'h0,         32'hCAFE_0008, 32'h0});
        vecs.push_back('{4'd10, 1'b0, 16'd7,  32'h0BAD_F00D, 16'd2,   32'h0,         32'h0BAD_F00D, 32'h0});

        // Reset holds every select high even with global_csb asserted on a zero frame.
        repeat (3) @(negedge gpio_clk);
        #1;
        check("rst_csb", {80'd0, sram_csb1, sram_csb0}, {80'd0, 32'hFFFF_FFFF});
        check("rst_gpio_out", {111'd0, gpio_out}, 112'd0);
        global_csb = 1'b1;
        @(negedge gpio_clk);
        gpio_resetn = 1'b1;
        sb_q.push_back(112'd0);
        shift_frame(112'd0, 1'b1, "rst_frame");

        pat_a = {14{8'hA5}};
        pat_b = {14{8'h5A}};
        shift_frame(pat_a, 1'b0, "");
        sb_q.push_back(pat_a);
        shift_frame(pat_b, 1'b1, "loopback");

        foreach (vecs[i]) begin
            if (vecs[i].dual) begin
                wr(mk(vecs[i].sel, vecs[i].a0, vecs[i].d0, 1'b0, 1'b0, 4'hF,
                      16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
                wr(mk(vecs[i].sel, vecs[i].a1, vecs[i].d1, 1'b0, 1'b0, 4'hF,
                      16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
                rd(mk(vecs[i].sel, vecs[i].a0, 32'h0000_FFFF, 1'b0, 1'b1, 4'hF,
                      vecs[i].a1, 32'h0000_FFFF, 1'b0, 1'b1, 4'hF),
                   mk(vecs[i].sel, vecs[i].a0, vecs[i].exp0, 1'b0, 1'b1, 4'hF,
                      vecs[i].a1, vecs[i].exp1, 1'b0, 1'b1, 4'hF),
                   $sformatf("dp_sel%0d", vecs[i].sel));
            end else begin
                wr(mk(vecs[i].sel, vecs[i].a0, vecs[i].d0, 1'b0, 1'b0, 4'hF,
                      16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
                rd(mk(vecs[i].sel, vecs[i].a0, 32'h0000_FFFF, 1'b0, 1'b1, 4'hF,
                      vecs[i].a1, 32'hFFFF_FFFF, 1'b1, 1'b1, 4'hF),
                   mk(vecs[i].sel, vecs[i].a0, vecs[i].exp0, 1'b0, 1'b1, 4'hF,
                      vecs[i].a1, vecs[i].exp1, 1'b1, 1'b1, 4'hF),
                   $sformatf("sp_sel%0d", vecs[i].sel));
            end
        end

        // Byte-masked write: only bytes 0 and 2 are replaced.
        wr(mk(4'd4, 16'd7, 32'h1122_3344, 1'b0, 1'b0, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
        wr(mk(4'd4, 16'd7, 32'hAABB_CCDD, 1'b0, 1'b0, 4'b0101, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF));
        rd(mk(4'd4, 16'd7, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF),
           mk(4'd4, 16'd7, 32'h11BB_33DD, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF),
           "wmask");

        // Write through port 1 only, read back through port 0.
        wr(mk(4'd6, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF, 16'd9, 32'hCAFE_F00D, 1'b0, 1'b0, 4'hF));
        rd(mk(4'd6, 16'd9, 32'd0, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF),
           mk(4'd6, 16'd9, 32'hCAFE_F00D, 1'b0, 1'b1, 4'hF, 16'd0, 32'd0, 1'b1, 1'b1, 4'hF),
           "port1_write");

        // Asynchronous reset mid-access clears the frame and drops the selects at once.
        shift_frame(mk(4'd2, 16'd1, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF,
                       16'hFFFF, 32'hFFFF_FFFF, 1'b0, 1'b1, 4'hF), 1'b0, "");
        @(negedge gpio_clk);
        global_csb = 1'b0;
        #1;
        check("pre_rst_gpio_out", {111'd0, gpio_out}, 112'd0);
        check("pre_rst_csb0", {96'd0, sram_csb0}, {96'd0, 16'hFFFB});
        #2;
        gpio_resetn = 1'b0;
        #1;
        check("async_rst_csb", {80'd0, sram_csb1, sram_csb0}, {80'd0, 32'hFFFF_FFFF});
        global_csb = 1'b1;
        @(negedge gpio_clk);
        gpio_resetn = 1'b1;
        sb_q.push_back(112'd0);
        shift_frame(112'd0, 1'b1, "async_rst_frame");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/gpio_sram_scan_ctrl.md
# gpio_sram_scan_ctrl

Serial scan-chain controller that lets an external tester drive the on-chip OpenRAM test SRAMs through a handful of GPIOs. A 112-bit shift register is loaded bit-serially with a command frame. Asserting a global chip-select applies the frame to one selected SRAM. Read data is captured, loaded back into the frame and shifted out. It sits in the user project area between the GPIO pad mux (GPIO/LA test mode, gpio_clk selected) and the SRAM macro array.

## Interface
- NUM_SRAM, 16: number of SRAM slots addressed by `sel`.
- NUM_DP, 8: slots 0..NUM_DP-1 are dual-port (1RW+1R/RW); the rest are single-port.
- gpio_clk  in  1  scan and SRAM clock; all state on rising edge.
- gpio_resetn  in  1  asynchronous, active-low reset.
- gpio_in  in  1  serial scan data in.
- gpio_scan  in  1  shift enable.
- gpio_sram_load  in  1  load captured read data into the frame.
- global_csb  in  1  active-low access strobe.
- gpio_out  out  1  serial scan data out = frame[111].
- sram_csb0, sram_csb1  out  NUM_SRAM  per-slot active-low chip selects.
- sram_web0, sram_web1  out  1  broadcast write enables (active-low).
- sram_wmask0, sram_wmask1  out  4  broadcast byte write masks.
- sram_addr0, sram_addr1  out  16  broadcast addresses.
- sram_din0, sram_din1  out  32  broadcast write data.
- sram_dout0, sram_dout1  in  NUM_SRAM*32  flattened read data, slot k at [32k+31:32k].

## Operation
- Frame layout, MSB first (bit 111 shifted in first): sel[3:0], addr0[15:0], din0[31:0], csb0, web0, wmask0[3:0], addr1[15:0], din1[31:0], csb1, web1, wmask1[3:0].
- Shift: when gpio_scan=1, on each edge frame <= {frame[110:0], gpio_in}. gpio_out is frame[111], driven combinationally from the register.
- Access: sram_csb0[k] = global_csb | frame.csb0 | (sel != k). sram_csb1[k] uses the same rule with frame.csb1, and is forced to 1 for k >= NUM_DP. Address, din, web and wmask are broadcast from the frame fields.
- Capture: the edge after any edge where global_csb was 0 loads dout0_q/dout1_q from the selected slot. dout1_q is 0 for single-port slots or when csb1 was high.
- Load: when gpio_sram_load=1 and gpio_scan=0, frame.din0 <= dout0_q and frame.din1 <= dout1_q. All other fields are kept.
- Priority when inputs overlap: gpio_scan wins over gpio_sram_load. Frame fields are held stable during an access.
- While gpio_resetn=0: all csb outputs are forced to 1.

## Timing
- Reset values: frame = 0, dout0_q = dout1_q = 0, access flag = 0, gpio_out = 0.
- Write sequence: 112 shift cycles, then 1 cycle with global_csb=0. The SRAM writes on that edge.
- Read sequence:
  - access cycle: global_csb=0;
  - capture edge: next edge after the access;
  - load cycle: gpio_sram_load=1;
  - scan-out: gpio_scan=1.
- After the load edge, gpio_out shows frame[111] immediately, before the first shift edge. Bits then appear one per edge.
- Read-to-first-output-bit latency: 3 edges.
- Asynchronous reset in mid-scan clears the frame immediately. Any access then in progress is aborted with csb high.

## Structure
- Shared package: frame field offsets and widths (SEL_MSB, ADDR0_LSB, …), FRAME_W=112, NUM_SRAM, NUM_DP.
- One sub-module is natural: `scan_frame_reg`, holding the 112-bit shift/load register.
- Top level holds the csb decode, the dout mux and the capture registers.

## Test plan
- Reset: with gpio_resetn low, all csb outputs read 1 and gpio_out=0. After release, the frame is 0.
- Scan loopback: shift in 112 bits of 0xA5 pattern, then 112 more. gpio_out must replay the first pattern bit-exact.
- Dual-port write/read, sel=3:
  - write addr0=1, din0=3;
  - write addr0=2, din0=0x18;
  - read port0 addr 1 and port1 addr 2 with din fields shifted as 0x0000FFFF.
  - Scan-out must equal {3, 16'd1, 32'd3, 0, 1, 4'hF, 16'd2, 32'h18, 0, 1, 4'hF}.
- Single-port, sel=9: write 0xDEADBEEF to addr 1, then read it back with csb1=1. Scan-out must show din0=0xDEADBEEF and din1=0.
- Sweep: run the dual-port scenario for sel 0..6 and the single-port scenario for sel 8..10. There must be no mismatch and no X on gpio_out.
- Isolation: an access with sel=5 asserts only sram_csb0[5] (and sram_csb1[5] if enabled), for exactly one cycle.
